// File: rtl/prvp_apb_pkg.sv
// Shared types and constants for the APB3 initiator (prvp_apb_master_if).
package prvp_apb_pkg;

  localparam int unsigned APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_e;

endpackage

// File: rtl/prvp_apb_master_if_if.sv
// Request/response channels plus APB3 bus of the APB initiator, with master (initiator) and slave views.
interface prvp_apb_master_if_if #(
  parameter int unsigned APB_ADDR_WIDTH = 12
);

  localparam int unsigned DW = prvp_apb_pkg::APB_DATA_WIDTH;

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [APB_ADDR_WIDTH-1:0] req_addr;
  logic [DW-1:0]             req_wdata;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DW-1:0]             rsp_rdata;
  logic                      rsp_err;
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [DW-1:0]             PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [DW-1:0]             PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

endinterface

// File: rtl/prvp_apb_master_if.sv
// APB3 initiator: one valid/ready request -> one APB transfer -> one valid/ready response.
// Optional ACCESS-phase timeout enabled by defining PRVP_APB_MASTER_TIMEOUT_EN.
module prvp_apb_master_if
  import prvp_apb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic                HCLK,
  input logic                HRESETn,
  prvp_apb_master_if_if.master bus
);

  apb_mst_state_e            state;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q;
  logic                      pwrite_q;
  logic                      psel_q;
  logic                      penable_q;
  logic                      rsp_valid_q;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q;
  logic                      rsp_err_q;

`ifdef PRVP_APB_MASTER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

  assign bus.req_ready = (state == IDLE);
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // ACCESS covers the APB setup cycle (PENABLE=0) then the wait/complete cycles (PENABLE=1).
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef PRVP_APB_MASTER_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            pwrite_q <= bus.req_write;
            paddr_q  <= bus.req_addr;
            pwdata_q <= bus.req_wdata;
            state    <= SETUP;
          end
        end
        SETUP: begin
          psel_q    <= 1'b1;
          penable_q <= 1'b0;
`ifdef PRVP_APB_MASTER_TIMEOUT_EN
          tmo_cnt   <= '0;
`endif
          state     <= ACCESS;
        end
        ACCESS: begin
          if (!penable_q) begin
            penable_q <= 1'b1;
          end else if (bus.PREADY) begin
            rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA;
            rsp_err_q   <= bus.PSLVERR;
            rsp_valid_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state       <= RESP;
          end
`ifdef PRVP_APB_MASTER_TIMEOUT_EN
          else if (tmo_hit) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state       <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prvp_apb_master_if.sv
// Directed self-checking bench for prvp_apb_master_if (timeout case follows PRVP_APB_MASTER_TIMEOUT_EN).
module tb_prvp_apb_master_if;

  logic HCLK;
  logic HRESETn;
  int   n_assert;
  int   n_fail;

  prvp_apb_master_if_if #(.APB_ADDR_WIDTH(12)) bus ();

  prvp_apb_master_if #(
    .APB_ADDR_WIDTH (12),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic wr, input logic [11:0] addr, input logic [31:0] wd);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    HRESETn       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    bus.PRDATA    = 32'hDEAD_BEEF;
    bus.PREADY    = 1'b1;
    bus.PSLVERR   = 1'b0;

    // reset state
    #12;
    chk("rst_psel", 32'(bus.PSEL), 32'd0);
    chk("rst_penable", 32'(bus.PENABLE), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_paddr", 32'(bus.PADDR), 32'd0);
    HRESETn = 1'b1;
    tick();

    // 1: zero-wait write
    start_req(1'b1, 12'h004, 32'h0000_0010);
    chk("t1_e0_psel", 32'(bus.PSEL), 32'd0);
    chk("t1_e0_req_ready", 32'(bus.req_ready), 32'd0);
    chk("t1_e0_paddr", 32'(bus.PADDR), 32'h004);
    tick();
    chk("t1_e1_psel", 32'(bus.PSEL), 32'd1);
    chk("t1_e1_penable", 32'(bus.PENABLE), 32'd0);
    chk("t1_e1_pwrite", 32'(bus.PWRITE), 32'd1);
    tick();
    chk("t1_e2_penable", 32'(bus.PENABLE), 32'd1);
    chk("t1_e2_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t1_e2_pwdata", bus.PWDATA, 32'h0000_0010);
    tick();
    chk("t1_e3_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t1_e3_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("t1_e3_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("t1_e3_psel", 32'(bus.PSEL), 32'd0);
    chk("t1_e3_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    chk("t1_e4_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t1_e4_req_ready", 32'(bus.req_ready), 32'd1);

    // 2: read with three wait states
    bus.PREADY = 1'b0;
    start_req(1'b0, 12'h020, 32'h1111_2222);
    tick();
    chk("t2_e1_paddr", 32'(bus.PADDR), 32'h020);
    tick();
    chk("t2_e2_penable", 32'(bus.PENABLE), 32'd1);
    chk("t2_e2_pwrite", 32'(bus.PWRITE), 32'd0);
    tick();
    tick();
    chk("t2_e4_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t2_e4_paddr", 32'(bus.PADDR), 32'h020);
    tick();
    chk("t2_e5_penable", 32'(bus.PENABLE), 32'd1);
    chk("t2_e5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'hA5A5_1234;
    tick();
    chk("t2_e6_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t2_e6_rsp_rdata", bus.rsp_rdata, 32'hA5A5_1234);
    chk("t2_e6_paddr", 32'(bus.PADDR), 32'h020);
    bus.PRDATA = 32'hDEAD_BEEF;
    tick();

    // 3: slave error, then clean read
    bus.PSLVERR = 1'b1;
    start_req(1'b1, 12'h008, 32'h0000_00FF);
    tick();
    tick();
    tick();
    chk("t3_err_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t3_err", 32'(bus.rsp_err), 32'd1);
    bus.PSLVERR = 1'b0;
    tick();
    bus.PRDATA = 32'h1234_5678;
    start_req(1'b0, 12'h00C, 32'd0);
    tick();
    tick();
    tick();
    chk("t3_next_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t3_next_err", 32'(bus.rsp_err), 32'd0);
    chk("t3_next_rdata", bus.rsp_rdata, 32'h1234_5678);
    tick();

    // 4: response backpressure, competing request must not be taken
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = 32'h0000_CAFE;
    start_req(1'b0, 12'h010, 32'd0);
    tick();
    tick();
    tick();
    chk("t4_valid", 32'(bus.rsp_valid), 32'd1);
    bus.PRDATA    = 32'hFFFF_FFFF;
    bus.req_valid = 1'b1;
    bus.req_addr  = 12'h3FC;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("t4_hold_rdata", bus.rsp_rdata, 32'h0000_CAFE);
      chk("t4_hold_req_ready", 32'(bus.req_ready), 32'd0);
      chk("t4_hold_psel", 32'(bus.PSEL), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    chk("t4_resp_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    chk("t4_done_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t4_done_req_ready", 32'(bus.req_ready), 32'd1);
    chk("t4_paddr_kept", 32'(bus.PADDR), 32'h010);

    // 5: asynchronous reset in ACCESS
    bus.PREADY = 1'b0;
    start_req(1'b0, 12'h024, 32'd0);
    tick();
    tick();
    chk("t5_pre_penable", 32'(bus.PENABLE), 32'd1);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("t5_rst_psel", 32'(bus.PSEL), 32'd0);
    chk("t5_rst_penable", 32'(bus.PENABLE), 32'd0);
    chk("t5_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    #2;
    HRESETn = 1'b1;
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h0BAD_F00D;
    tick();
    chk("t5_req_ready", 32'(bus.req_ready), 32'd1);
    start_req(1'b0, 12'h030, 32'd0);
    tick();
    tick();
    tick();
    chk("t5_read_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t5_read_rdata", bus.rsp_rdata, 32'h0BAD_F00D);
    chk("t5_read_err", 32'(bus.rsp_err), 32'd0);
    tick();

    // 6: PREADY stuck low
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'h7777_7777;
    start_req(1'b0, 12'h040, 32'd0);
    tick();
    tick();
`ifdef PRVP_APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    chk("t6_e17_penable", 32'(bus.PENABLE), 32'd1);
    chk("t6_e17_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("t6_abort_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t6_abort_err", 32'(bus.rsp_err), 32'd1);
    chk("t6_abort_rdata", bus.rsp_rdata, 32'd0);
    chk("t6_abort_psel", 32'(bus.PSEL), 32'd0);
    tick();
    chk("t6_idle", 32'(bus.req_ready), 32'd1);
`else
    for (int i = 0; i < 1000; i++) tick();
    chk("t6_stuck_psel", 32'(bus.PSEL), 32'd1);
    chk("t6_stuck_penable", 32'(bus.PENABLE), 32'd1);
    chk("t6_stuck_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t6_stuck_req_ready", 32'(bus.req_ready), 32'd0);
    bus.PREADY = 1'b1;
    tick();
    chk("t6_late_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t6_late_rdata", bus.rsp_rdata, 32'h7777_7777);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
